// File: rtl/poly_voice_engine_if.sv
// Sample-tick, config and PCM bundle for poly_voice_engine.
// master = sample-clock/config side, slave = the engine.
interface poly_voice_engine_if #(
    parameter int VOICES      = 4,
    parameter int BITDEPTH    = 14,
    parameter int BITFRACTION = 6
);
    localparam int PW = BITDEPTH + BITFRACTION;
    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;

    logic                sample_clock;
    logic [VOICES-1:0]   gate;
    logic                cfg_we;
    logic [VW-1:0]       cfg_voice;
    logic [1:0]          cfg_sel;
    logic [PW-1:0]       cfg_data;
    logic [BITDEPTH-1:0] pcm;
    logic                pcm_valid;
    logic                busy;
    logic                overrun;

    modport master (
        output sample_clock, gate, cfg_we, cfg_voice, cfg_sel, cfg_data,
        input  pcm, pcm_valid, busy, overrun
    );

    modport slave (
        input  sample_clock, gate, cfg_we, cfg_voice, cfg_sel, cfg_data,
        output pcm, pcm_valid, busy, overrun
    );
endinterface

// File: rtl/poly_voice_engine.sv
// Time-multiplexed polyphonic voice engine: one voice per clk, saturating mix.
// Define POLY_NOISE_EN to build the LFSR noise waveform (otherwise wave 3 = saw).
module poly_voice_engine #(
    parameter int VOICES      = 4,
    parameter int BITDEPTH    = 14,
    parameter int BITFRACTION = 6
) (
    input logic                clk,
    input logic                rst_n,
    poly_voice_engine_if.slave bus
);
    localparam int B    = BITDEPTH;
    localparam int PW   = BITDEPTH + BITFRACTION;
    localparam int VW   = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int ACCW = BITDEPTH + $clog2(VOICES) + 1;

    localparam logic signed [ACCW-1:0] SAT_HI = ACCW'((1 << (B - 1)) - 1);
    localparam logic signed [ACCW-1:0] SAT_LO = -SAT_HI - ACCW'(1);
    localparam logic signed [ACCW-1:0] OFFSET = ACCW'(1 << (B - 1));

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 state;
    logic [VW-1:0]          slot;
    logic [VOICES-1:0]      gate_snap;
    logic signed [ACCW-1:0] acc;

    logic [PW-1:0] inc_r    [VOICES];
    logic [PW-1:0] phase_r  [VOICES];
    logic [1:0]    wave_r   [VOICES];
    logic [7:0]    attack_r [VOICES];
    logic [7:0]    decay_r  [VOICES];
    logic [7:0]    level_r  [VOICES];

`ifdef POLY_NOISE_EN
    logic [15:0] lfsr;
    logic [15:0] noise_snap;
    logic [15:0] lfsr_nxt;
    assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
`endif

    logic                   cfg_hit;
    logic [PW-1:0]          phase_nxt;
    logic [8:0]             lvl_sum;
    logic [7:0]             level_nxt;
    logic [B-1:0]           t_top;
    logic [B-1:0]           tri_u;
    logic [B-1:0]           u;
    logic signed [B-1:0]    s_val;
    logic signed [B+8:0]    prod;
    logic signed [ACCW-1:0] acc_nxt;
    logic [B-1:0]           pcm_nxt;

    assign cfg_hit = (32'(bus.cfg_voice) < 32'(VOICES));

    // NOTE: every signal is given a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        phase_nxt = phase_r[slot] + inc_r[slot];
        lvl_sum   = {1'b0, level_r[slot]} + {1'b0, attack_r[slot]};
        level_nxt = 8'd0;
        if (gate_snap[slot])
            level_nxt = lvl_sum[8] ? 8'hFF : lvl_sum[7:0];
        else if (level_r[slot] > decay_r[slot])
            level_nxt = level_r[slot] - decay_r[slot];

        t_top = phase_nxt[PW-1 -: B];
        tri_u = {t_top[B-2:0], 1'b0};
        u     = t_top;
        case (wave_r[slot])
            2'd1:    u = phase_nxt[PW-1] ? '0 : '1;
            2'd2:    u = phase_nxt[PW-1] ? ~tri_u : tri_u;
`ifdef POLY_NOISE_EN
            2'd3:    u = B'(noise_snap >> (16 - B));
`endif
            default: u = t_top;
        endcase

        // Offset-binary to two's complement is a flip of the MSB.
        s_val   = {~u[B-1], u[B-2:0]};
        prod    = (B+9)'(s_val) * (B+9)'($signed({1'b0, level_nxt}));
        acc_nxt = acc + ACCW'(prod >>> 8);

        if (acc_nxt > SAT_HI)      pcm_nxt = '1;
        else if (acc_nxt < SAT_LO) pcm_nxt = '0;
        else                       pcm_nxt = B'(acc_nxt + OFFSET);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            slot          <= '0;
            gate_snap     <= '0;
            acc           <= '0;
            bus.pcm       <= B'(1 << (B - 1));
            bus.pcm_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.overrun   <= 1'b0;
            // NOTE: the voice register file is deliberately reset: a silent,
            // phase-aligned start after reset is part of the block's contract.
            for (int i = 0; i < VOICES; i++) begin
                inc_r[i]    <= '0;
                phase_r[i]  <= '0;
                wave_r[i]   <= '0;
                attack_r[i] <= '0;
                decay_r[i]  <= '0;
                level_r[i]  <= '0;
            end
`ifdef POLY_NOISE_EN
            lfsr       <= 16'hACE1;
            noise_snap <= 16'hACE1;
`endif
        end else begin
            bus.pcm_valid <= 1'b0;
            bus.overrun   <= 1'b0;

            // Config lands at this edge; a slot running now still saw the old value.
            if (bus.cfg_we && cfg_hit) begin
                case (bus.cfg_sel)
                    2'd0: inc_r[bus.cfg_voice]    <= bus.cfg_data;
                    2'd1: wave_r[bus.cfg_voice]   <= bus.cfg_data[1:0];
                    2'd2: attack_r[bus.cfg_voice] <= bus.cfg_data[7:0];
                    default: decay_r[bus.cfg_voice] <= bus.cfg_data[7:0];
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (bus.sample_clock) begin
                        gate_snap <= bus.gate;
                        acc       <= '0;
                        slot      <= '0;
                        bus.busy  <= 1'b1;
                        state     <= S_RUN;
`ifdef POLY_NOISE_EN
                        noise_snap <= lfsr;
                        lfsr       <= lfsr_nxt;
`endif
                    end
                end
                S_RUN: begin
                    bus.overrun    <= bus.sample_clock;
                    phase_r[slot]  <= phase_nxt;
                    level_r[slot]  <= level_nxt;
                    acc            <= acc_nxt;
                    if (slot == VW'(VOICES - 1)) begin
                        // pcm is registered here so it is visible in the DONE cycle.
                        bus.pcm       <= pcm_nxt;
                        bus.pcm_valid <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        slot <= slot + VW'(1);
                    end
                end
                default: begin
                    bus.overrun <= bus.sample_clock;
                    bus.busy    <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_poly_voice_engine.sv
// Directed, table-driven bench for poly_voice_engine (VOICES=4, B=14, F=6).
// Expected values follow POLY_NOISE_EN when the bench is built with it.
module tb_poly_voice_engine;
    localparam int VOICES = 4;
    localparam int B      = 14;
    localparam int F      = 6;
    localparam int MID    = 1 << (B - 1);

    typedef struct {
        string name;
        int    wave;
        int    inc;
        int    attack;
        int    gate;
        int    exp_pcm;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    poly_voice_engine_if #(.VOICES(VOICES), .BITDEPTH(B), .BITFRACTION(F)) bus ();

    poly_voice_engine #(.VOICES(VOICES), .BITDEPTH(B), .BITFRACTION(F)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_pcm_of(input int u, input int level);
        int s;
        s = u - MID;
        return MID + ((s * level) >>> 8);
    endfunction

    function automatic int lfsr_step(input int l);
        return (l & 1) ? ((l >> 1) ^ 'hB400) : (l >> 1);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n            = 1'b0;
        bus.sample_clock = 1'b0;
        bus.gate         = '0;
        bus.cfg_we       = 1'b0;
        bus.cfg_voice    = '0;
        bus.cfg_sel      = '0;
        bus.cfg_data     = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cfg_write(input int v, input int sel, input int data);
        bus.cfg_we    = 1'b1;
        bus.cfg_voice = 2'(v);
        bus.cfg_sel   = 2'(sel);
        bus.cfg_data  = 20'(data);
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic set_voice(input int v, input int wave, input int inc, input int attack);
        cfg_write(v, 1, wave);
        cfg_write(v, 0, inc);
        cfg_write(v, 2, attack);
    endtask

    // One sample tick; checks busy and valid latency, returns the pcm word.
    task automatic tick(output int pcm_val);
        int lat;
        bus.sample_clock = 1'b1;
        @(negedge clk);
        bus.sample_clock = 1'b0;
        check("busy_start", int'(bus.busy), 1);
        lat = 1;
        while (!bus.pcm_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("valid_latency", lat, VOICES + 1);
        pcm_val = int'(bus.pcm);
        @(negedge clk);
        check("valid_pulse_end", int'(bus.pcm_valid), 0);
        check("busy_end", int'(bus.busy), 0);
    endtask

    // Tick with a second sample_clock at negedge index second_at.
    task automatic overrun_run(input int second_at, output int ov, output int vc);
        ov = 0;
        vc = 0;
        bus.sample_clock = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            ov += int'(bus.overrun);
            vc += int'(bus.pcm_valid);
            bus.sample_clock = (i == second_at);
        end
        bus.sample_clock = 1'b0;
    endtask

    initial begin
        vec_t vecs[8];
        int   p;
        int   ov;
        int   vc;
        int   l;

        vecs[0] = '{"all_zero",      0, 0,       0,   0, MID};
        vecs[1] = '{"saw_quarter",   0, 'h40000, 255, 1, 4112};
        vecs[2] = '{"square_hi",     1, 1,       255, 1, 16351};
        vecs[3] = '{"square_lo",     1, 'h80000, 255, 1, 32};
        vecs[4] = '{"tri_rise",      2, 'h20000, 255, 1, 4112};
        vecs[5] = '{"tri_fall_floor", 2, 'hC0000, 255, 1, 8191};
        vecs[6] = '{"saw_half_lvl",  0, 'h40000, 128, 1, 6144};
`ifdef POLY_NOISE_EN
        vecs[7] = '{"wave3_noise",   3, 'h40000, 255, 1, 11052};
`else
        vecs[7] = '{"wave3_as_saw",  3, 'h40000, 255, 1, 4112};
`endif

        // Reset values, during and after reset.
        bus.sample_clock = 1'b0;
        bus.gate         = '0;
        bus.cfg_we       = 1'b0;
        bus.cfg_voice    = '0;
        bus.cfg_sel      = '0;
        bus.cfg_data     = '0;
        repeat (2) @(negedge clk);
        check("rst_pcm", int'(bus.pcm), MID);
        check("rst_valid", int'(bus.pcm_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        do_reset();
        check("post_rst_pcm", int'(bus.pcm), MID);
        check("post_rst_busy", int'(bus.busy), 0);

        // Single-tick table on voice 0, fresh reset per vector.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            set_voice(0, vecs[i].wave, vecs[i].inc, vecs[i].attack);
            bus.gate = 4'(vecs[i].gate);
            tick(p);
            check(vecs[i].name, p, vecs[i].exp_pcm);
        end

        // Saturation: all four voices at full-scale square, both polarities.
        do_reset();
        for (int v = 0; v < VOICES; v++) set_voice(v, 1, 1, 255);
        bus.gate = 4'hF;
        tick(p);
        check("sat_high", p, (1 << B) - 1);
        for (int v = 0; v < VOICES; v++) cfg_write(v, 0, 'h80000);
        tick(p);
        check("sat_low", p, 0);

        // Release ramp: 255 down by 16 per tick to 0.
        do_reset();
        set_voice(0, 1, 1, 255);
        cfg_write(0, 3, 16);
        bus.gate = 4'b0001;
        tick(p);
        check("release_attack", p, 16351);
        bus.gate = 4'b0000;
        for (int k = 1; k <= 16; k++) begin
            l = 255 - 16 * k;
            if (l < 0) l = 0;
            tick(p);
            check($sformatf("release_%0d", k), p, exp_pcm_of((1 << B) - 1, l));
        end

        // Overrun in RUN and in the DONE cycle: one pulse, one pcm_valid each.
        do_reset();
        overrun_run(2, ov, vc);
        check("overrun_run_pulses", ov, 1);
        check("overrun_run_valids", vc, 1);
        overrun_run(5, ov, vc);
        check("overrun_done_pulses", ov, 1);
        check("overrun_done_valids", vc, 1);

        // Config write to voice 2 during slot 2: old inc used this tick.
        do_reset();
        set_voice(2, 0, 0, 255);
        bus.gate = 4'b0100;
        bus.sample_clock = 1'b1;
        @(negedge clk);
        bus.sample_clock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cfg_write(2, 0, 'h40000);
        @(negedge clk);
        check("collide_valid", int'(bus.pcm_valid), 1);
        check("collide_old_inc", int'(bus.pcm), 32);
        @(negedge clk);
        tick(p);
        check("collide_new_inc", p, 4112);

        // Wave 3 over two ticks: LFSR sequence or plain saw.
        do_reset();
        set_voice(0, 3, 'h40000, 255);
        bus.gate = 4'b0001;
`ifdef POLY_NOISE_EN
        l = 'hACE1;
        tick(p);
        check("noise_t1", p, exp_pcm_of(l >> 2, 255));
        l = lfsr_step(l);
        tick(p);
        check("noise_t2", p, exp_pcm_of(l >> 2, 255));
`else
        tick(p);
        check("wave3_t1", p, 4112);
        tick(p);
        check("wave3_t2", p, MID);
`endif

        // Reset asserted in slot 2 aborts the computation.
        do_reset();
        set_voice(0, 0, 'h40000, 255);
        bus.gate = 4'b0001;
        tick(p);
        check("pre_abort_pcm", p, 4112);
        bus.sample_clock = 1'b1;
        @(negedge clk);
        bus.sample_clock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_pcm", int'(bus.pcm), MID);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_valid", int'(bus.pcm_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        vc = 0;
        repeat (10) begin
            @(negedge clk);
            vc += int'(bus.pcm_valid);
        end
        check("abort_no_valid", vc, 0);
        check("abort_pcm_hold", int'(bus.pcm), MID);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
